mips_datapath: RTL and testbench

//  Datapath of a single-cycle 32-bit MIPS core: PC register and next-PC logic, 32x32 register file,

---
 rtl/mips_datapath_pkg.sv | 23 ++
 rtl/mips_reg_file.sv | 35 +++
 rtl/mips_datapath.sv | 93 +++++++++
 tb/tb_mips_datapath.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_datapath_pkg.sv
// Shared constants for the single-cycle MIPS datapath: word and register-address widths and
// the ALU operation encodings driven by the ALU control decoder.
package mips_datapath_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 32;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Signed less-than yielding a 0/1 word.
  function automatic logic [XLEN-1:0] slt_word(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [XLEN-1:0] res;
    res    = '0;
    res[0] = ($signed(a) < $signed(b));
    return res;
  endfunction

endpackage

// File: rtl/mips_reg_file.sv
// 32x32 register file: two combinational read ports, one synchronous write port,
// asynchronous active-low clear, register 0 hardwired to zero.
module mips_reg_file
  import mips_datapath_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] ra1,
  input  logic [REG_ADDR_W-1:0] ra2,
  input  logic [REG_ADDR_W-1:0] wa,
  input  logic [XLEN-1:0]       wd,
  input  logic                  we,
  output logic [XLEN-1:0]       rd1,
  output logic [XLEN-1:0]       rd2
);

  logic [XLEN-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        regs_q[i] <= '0;
      end
    end else if (we && (wa != '0)) begin
      regs_q[wa] <= wd;
    end
  end

  // Reads see the pre-edge contents, so a same-cycle write is not forwarded.
  always_comb begin
    rd1 = (ra1 == '0) ? '0 : regs_q[ra1];
    rd2 = (ra2 == '0) ? '0 : regs_q[ra2];
  end

endmodule

// File: rtl/mips_datapath.sv
// Single-cycle MIPS datapath: PC register and next-PC selection, register file, sign
// extension, operand/result muxes and the ALU. Control comes from external decoders.
module mips_datapath
  import mips_datapath_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic [25:0]     instruction,
  input  logic [XLEN-1:0] read_data,
  input  logic [2:0]      alu_control,
  input  logic            PC_src,
  input  logic            mem_to_reg,
  input  logic            alu_src,
  input  logic            reg_dest,
  input  logic            reg_write,
  input  logic            jump,
  output logic            zero_flag,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] alu_out,
  output logic [XLEN-1:0] write_data
);

  logic [REG_ADDR_W-1:0] rs, rt, rd, write_reg;
  logic [15:0]           imm;
  logic [XLEN-1:0]       signimm, pc_plus4, branch_tgt, jump_tgt, pc_next;
  logic [XLEN-1:0]       src_a, src_b, rd2, result;
  logic [XLEN-1:0]       pc_q;

  assign rs  = instruction[25:21];
  assign rt  = instruction[20:16];
  assign rd  = instruction[15:11];
  assign imm = instruction[15:0];

  assign signimm = {{16{imm[15]}}, imm};

  // Next-PC selection; jump takes priority over a taken branch.
  always_comb begin
    pc_plus4   = pc_q + 32'd4;
    branch_tgt = pc_plus4 + {signimm[XLEN-3:0], 2'b00};
    jump_tgt   = {pc_plus4[31:28], instruction[25:0], 2'b00};
    if (jump) begin
      pc_next = jump_tgt;
    end else if (PC_src) begin
      pc_next = branch_tgt;
    end else begin
      pc_next = pc_plus4;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_next;
    end
  end

  assign PC = pc_q;

  assign write_reg = reg_dest ? rd : rt;
  assign result    = mem_to_reg ? read_data : alu_out;

  mips_reg_file u_reg_file (
    .clk   (clk),
    .reset (reset),
    .ra1   (rs),
    .ra2   (rt),
    .wa    (write_reg),
    .wd    (result),
    .we    (reg_write),
    .rd1   (src_a),
    .rd2   (rd2)
  );

  assign src_b      = alu_src ? signimm : rd2;
  assign write_data = rd2;

  // Unused encodings produce zero so zero_flag stays well defined.
  always_comb begin
    alu_out = '0;
    case (alu_control)
      ALU_AND: alu_out = src_a & src_b;
      ALU_OR:  alu_out = src_a | src_b;
      ALU_ADD: alu_out = src_a + src_b;
      ALU_SUB: alu_out = src_a - src_b;
      ALU_SLT: alu_out = slt_word(src_a, src_b);
      default: alu_out = '0;
    endcase
  end

  assign zero_flag = (alu_out == '0);

endmodule

// File: tb/tb_mips_datapath.sv
// Self-checking bench for mips_datapath: directed scenarios plus random instructions,
// compared every cycle against an architectural model (PC value + register array).
module tb_mips_datapath;

  logic        clk;
  logic        reset;
  logic [25:0] instruction;
  logic [31:0] read_data;
  logic [2:0]  alu_control;
  logic        PC_src, mem_to_reg, alu_src, reg_dest, reg_write, jump;
  logic        zero_flag;
  logic [31:0] PC, alu_out, write_data;

  mips_datapath dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .read_data   (read_data),
    .alu_control (alu_control),
    .PC_src      (PC_src),
    .mem_to_reg  (mem_to_reg),
    .alu_src     (alu_src),
    .reg_dest    (reg_dest),
    .reg_write   (reg_write),
    .jump        (jump),
    .zero_flag   (zero_flag),
    .PC          (PC),
    .alu_out     (alu_out),
    .write_data  (write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Architectural model state.
  logic [31:0] m_pc;
  logic [31:0] m_regs [32];
  logic [31:0] m_alu;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_reg(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : m_regs[a];
  endfunction

  function automatic logic [31:0] sext(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] m_alu_fn(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic void m_clear();
    m_pc = 32'd0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
  endfunction

  // Compare every visible output against the model for the current inputs.
  task automatic compare();
    logic [31:0] a, b;
    a     = m_reg(instruction[25:21]);
    b     = alu_src ? sext(instruction[15:0]) : m_reg(instruction[20:16]);
    m_alu = m_alu_fn(alu_control, a, b);
    check("pc", PC, m_pc);
    check("alu_out", alu_out, m_alu);
    check("zero_flag", {31'd0, zero_flag}, {31'd0, (m_alu == 32'd0)});
    check("write_data", write_data, m_reg(instruction[20:16]));
  endtask

  task automatic apply(input logic [25:0] ins, input logic [31:0] rdat, input logic [2:0] op,
                       input logic pcs, input logic m2r, input logic asrc, input logic rdst,
                       input logic rw, input logic jmp);
    @(negedge clk);
    instruction = ins; read_data = rdat; alu_control = op; PC_src = pcs;
    mem_to_reg = m2r; alu_src = asrc; reg_dest = rdst; reg_write = rw; jump = jmp;
    #2;
    compare();
  endtask

  // Advance the model across one rising edge.
  task automatic tick();
    logic [31:0] pc4, data;
    logic [4:0]  wa;
    @(posedge clk);
    if (reset) begin
      pc4 = m_pc + 32'd4;
      if (reg_write) begin
        wa   = reg_dest ? instruction[15:11] : instruction[20:16];
        data = mem_to_reg ? read_data : m_alu;
        if (wa != 5'd0) m_regs[wa] = data;
      end
      if (jump) m_pc = {pc4[31:28], instruction, 2'b00};
      else if (PC_src) m_pc = pc4 + (sext(instruction[15:0]) << 2);
      else m_pc = pc4;
    end
    #1;
  endtask

  function automatic logic [25:0] itype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [15:0] imm);
    return {rs, rt, imm};
  endfunction

  initial begin
    m_clear();
    reset = 1'b0;
    instruction = '0; read_data = '0; alu_control = 3'b010;
    PC_src = 0; mem_to_reg = 0; alu_src = 0; reg_dest = 0; reg_write = 0; jump = 0;

    // Reset state.
    #2;
    compare();
    check("reset_pc_lit", PC, 32'h0);
    check("reset_zero_lit", {31'd0, zero_flag}, 32'd1);
    @(posedge clk); #1;
    check("reset_hold_pc", PC, 32'h0);

    @(negedge clk);
    reset = 1'b1;
    tick();
    check("pc_after_release", PC, 32'h4);

    // Branch at PC=4 with imm=2 -> 0x10; SUB of equal regs gives zero.
    apply(itype(5'd8, 5'd9, 16'h0002), 32'd0, 3'b110, 1, 0, 0, 0, 0, 0);
    check("sub_equal_zero", {31'd0, zero_flag}, 32'd1);
    tick();
    check("branch_pc", PC, 32'h10);

    // Jump beats branch: target 0x4.
    apply(26'h0000001, 32'd0, 3'b010, 1, 0, 0, 0, 0, 1);
    tick();
    check("jump_pc", PC, 32'h4);

    // R-type ADD r16 = r8 + r9 = 0.
    apply({5'd8, 5'd9, 5'd16, 11'd0}, 32'd0, 3'b010, 0, 0, 0, 1, 1, 0);
    check("add_alu_lit", alu_out, 32'h0);
    tick();
    check("add_pc", PC, 32'h8);

    // lw r16 <- 0xDEADBEEF, then read back via rt.
    apply(itype(5'd8, 5'd16, 16'h0000), 32'hDEADBEEF, 3'b010, 0, 1, 1, 0, 1, 0);
    check("lw_addr_lit", alu_out, 32'h0);
    tick();
    apply(itype(5'd0, 5'd16, 16'h0000), 32'd0, 3'b010, 0, 0, 0, 0, 0, 0);
    check("lw_readback_lit", write_data, 32'hDEADBEEF);
    tick();

    // Load r1 = -1, then sweep ALU ops with B = imm 1.
    apply(itype(5'd0, 5'd1, 16'h0000), 32'hFFFFFFFF, 3'b010, 0, 1, 1, 0, 1, 0);
    tick();
    apply(itype(5'd1, 5'd0, 16'h0001), 32'd0, 3'b010, 0, 0, 1, 0, 0, 0);
    check("sweep_add", alu_out, 32'h0);
    tick();
    apply(itype(5'd1, 5'd0, 16'h0001), 32'd0, 3'b110, 0, 0, 1, 0, 0, 0);
    check("sweep_sub", alu_out, 32'hFFFFFFFE);
    tick();
    apply(itype(5'd1, 5'd0, 16'h0001), 32'd0, 3'b111, 0, 0, 1, 0, 0, 0);
    check("sweep_slt", alu_out, 32'h1);
    tick();
    apply(itype(5'd1, 5'd0, 16'h0001), 32'd0, 3'b000, 0, 0, 1, 0, 0, 0);
    check("sweep_and", alu_out, 32'h1);
    tick();
    apply(itype(5'd1, 5'd0, 16'h0001), 32'd0, 3'b001, 0, 0, 1, 0, 0, 0);
    check("sweep_or", alu_out, 32'hFFFFFFFF);
    tick();
    apply(itype(5'd1, 5'd0, 16'h0001), 32'd0, 3'b011, 0, 0, 1, 0, 0, 0);
    check("sweep_undef", alu_out, 32'h0);
    tick();

    // Write to r0 is ignored.
    apply(itype(5'd0, 5'd0, 16'h0000), 32'h12345678, 3'b010, 0, 1, 0, 0, 1, 0);
    tick();
    apply(itype(5'd0, 5'd0, 16'h0000), 32'd0, 3'b010, 0, 0, 0, 0, 0, 0);
    check("r0_readback", write_data, 32'h0);
    tick();

    // Random instructions; mostly sequential, occasional branch/jump.
    for (int i = 0; i < 400; i++) begin
      apply(26'($urandom), $urandom, 3'($urandom), ($urandom_range(0, 7) == 0),
            1'($urandom), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0));
      tick();
    end

    // Make r1 nonzero, then assert reset mid-cycle: PC and regs clear immediately.
    apply(itype(5'd0, 5'd1, 16'h0000), 32'hA5A5A5A5, 3'b010, 0, 1, 0, 0, 1, 0);
    tick();
    @(negedge clk);
    instruction = itype(5'd1, 5'd1, 16'h0000); reg_write = 0; jump = 0; PC_src = 0;
    alu_src = 0; alu_control = 3'b010;
    #1;
    check("pre_reset_r1", write_data, 32'hA5A5A5A5);
    reset = 1'b0;
    m_clear();
    #1;
    check("midrun_reset_pc", PC, 32'h0);
    check("midrun_reset_reg", write_data, 32'h0);
    compare();
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("post_reset_pc", PC, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
